wishbone_master_if: RTL and testbench

Parametrised Wishbone B4 classic-cycle master interface that sits between a CPU pipeline port (instruction or data side) and the Wishbone bus. It is the successor of the fixed 32-bit OpenMIPS bus interface and adds:
- configurable address, data and stall widths;
- slave error (`err_i`) and retry (`rty_i`) termination, with a bounded number of retries;
- a watchdog timeout;
- an error indication back to the pipeline.

It stalls the pipeline for the whole bus cycle, and holds the result steady while other pipeline stalls are pending.

---
 rtl/wishbone_master_if.sv | 186 ++++++++++++++++++
 tb/tb_wishbone_master_if.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master_if.sv
// Wishbone B4 classic-cycle master between a CPU pipeline port and the bus.
// The pipeline is stalled for the whole bus cycle. Slave retry, slave error and a watchdog are handled here.
module wishbone_master_if #(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int STALL_W   = 6,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 255,
   localparam int SW       = DW / 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall_i,
   input  logic               flush_i,
   input  logic               cpu_ce_i,
   input  logic [AW-1:0]      cpu_addr_i,
   input  logic [DW-1:0]      cpu_data_i,
   input  logic               cpu_we_i,
   input  logic [SW-1:0]      cpu_sel_i,
   output logic [DW-1:0]      cpu_data_o,
   output logic               cpu_err_o,
   output logic               stallreq,
   output logic [AW-1:0]      wb_adr_o,
   output logic [DW-1:0]      wb_dat_o,
   output logic               wb_we_o,
   output logic [SW-1:0]      wb_sel_o,
   output logic               wb_stb_o,
   output logic               wb_cyc_o,
   input  logic [DW-1:0]      wb_dat_i,
   input  logic               wb_ack_i,
   input  logic               wb_err_i,
   input  logic               wb_rty_i
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TO_LAST   = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_BACKOFF,
      ST_HOLD
   } state_t;

   state_t        state_reg;
   logic [DW-1:0] rd_buf_reg;
   logic          err_buf_reg;
   logic [RW-1:0] retry_cnt_reg;
   logic [TW-1:0] to_cnt_reg;

   logic any_resp;
   logic rty_limit;
   logic timeout_hit;
   logic busy_ack;
   logic busy_fail;
   logic busy_retry;
   logic busy_flush;

   // BUSY terminations, already resolved in priority order: ack > error > retry > flush.
   assign any_resp    = wb_ack_i | wb_err_i | wb_rty_i;
   assign rty_limit   = wb_rty_i && (retry_cnt_reg == RETRY_MAX);
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST) && !any_resp;
   assign busy_ack    = (state_reg == ST_BUSY) && wb_ack_i;
   assign busy_fail   = (state_reg == ST_BUSY) && !wb_ack_i && (wb_err_i || rty_limit || timeout_hit);
   assign busy_retry  = (state_reg == ST_BUSY) && !wb_ack_i && !wb_err_i && wb_rty_i
                        && (retry_cnt_reg < RETRY_MAX);
   assign busy_flush  = (state_reg == ST_BUSY) && !busy_ack && !busy_fail && !busy_retry && flush_i;

   always_comb begin
      stallreq   = 1'b0;
      cpu_data_o = '0;
      cpu_err_o  = 1'b0;
      if (!rst) begin
         case (state_reg)
            ST_IDLE: stallreq = cpu_ce_i && !flush_i;
            ST_BUSY: begin
               if (busy_ack) begin
                  cpu_data_o = wb_we_o ? '0 : wb_dat_i;
               end else if (busy_fail) begin
                  cpu_err_o = 1'b1;
               end else if (busy_retry) begin
                  stallreq = 1'b1;
               end else if (!busy_flush) begin
                  stallreq = 1'b1;
               end
            end
            ST_BACKOFF: stallreq = !flush_i;
            ST_HOLD: begin
               cpu_data_o = rd_buf_reg;
               cpu_err_o  = err_buf_reg;
            end
            default: stallreq = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         wb_adr_o      <= '0;
         wb_dat_o      <= '0;
         wb_we_o       <= 1'b0;
         wb_sel_o      <= '0;
         wb_stb_o      <= 1'b0;
         wb_cyc_o      <= 1'b0;
         rd_buf_reg    <= '0;
         err_buf_reg   <= 1'b0;
         retry_cnt_reg <= '0;
         to_cnt_reg    <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cpu_ce_i && !flush_i) begin
                  wb_adr_o      <= cpu_addr_i;
                  wb_dat_o      <= cpu_data_i;
                  wb_we_o       <= cpu_we_i;
                  wb_sel_o      <= cpu_sel_i;
                  wb_stb_o      <= 1'b1;
                  wb_cyc_o      <= 1'b1;
                  retry_cnt_reg <= '0;
                  to_cnt_reg    <= '0;
                  rd_buf_reg    <= '0;
                  err_buf_reg   <= 1'b0;
                  state_reg     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (busy_ack || busy_fail || busy_flush) begin
                  wb_adr_o <= '0;
                  wb_dat_o <= '0;
                  wb_we_o  <= 1'b0;
                  wb_sel_o <= '0;
                  wb_stb_o <= 1'b0;
                  wb_cyc_o <= 1'b0;
               end
               if (busy_ack) begin
                  rd_buf_reg  <= wb_we_o ? '0 : wb_dat_i;
                  err_buf_reg <= 1'b0;
                  state_reg   <= (|stall_i) ? ST_HOLD : ST_IDLE;
               end else if (busy_fail) begin
                  rd_buf_reg  <= '0;
                  err_buf_reg <= 1'b1;
                  state_reg   <= (|stall_i) ? ST_HOLD : ST_IDLE;
               end else if (busy_retry) begin
                  // Request fields stay on the bus so BACKOFF can re-issue them unchanged.
                  wb_stb_o      <= 1'b0;
                  wb_cyc_o      <= 1'b0;
                  retry_cnt_reg <= retry_cnt_reg + 1'b1;
                  state_reg     <= ST_BACKOFF;
               end else if (busy_flush) begin
                  rd_buf_reg  <= '0;
                  err_buf_reg <= 1'b0;
                  state_reg   <= ST_IDLE;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 1'b1;
               end
            end
            ST_BACKOFF: begin
               if (flush_i) begin
                  wb_adr_o  <= '0;
                  wb_dat_o  <= '0;
                  wb_we_o   <= 1'b0;
                  wb_sel_o  <= '0;
                  wb_stb_o  <= 1'b0;
                  wb_cyc_o  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  wb_stb_o   <= 1'b1;
                  wb_cyc_o   <= 1'b1;
                  to_cnt_reg <= '0;
                  state_reg  <= ST_BUSY;
               end
            end
            ST_HOLD: begin
               if (stall_i == '0) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wishbone_master_if.sv
// Directed bench for wishbone_master_if: reads, writes, hold, retries, timeout, slave error and aborts.
module tb_wishbone_master_if;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        cpu_ce_i;
   logic [31:0] cpu_addr_i;
   logic [31:0] cpu_data_i;
   logic        cpu_we_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_o;
   logic        cpu_err_o;
   logic        stallreq;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic        wb_stb_o;
   logic        wb_cyc_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        wb_rty_i;

   int n_tests = 0;
   int n_fail  = 0;

   wishbone_master_if #(
      .AW(32), .DW(32), .STALL_W(6), .MAX_RETRY(3), .TIMEOUT(8)
   ) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
      .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
      .cpu_err_o(cpu_err_o), .stallreq(stallreq),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "bench time limit");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Cycle start is 1 time unit after the rising edge; sampling happens 2 units later.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic clear_bus_inputs;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_rty_i = 1'b0;
      wb_dat_i = '0;
   endtask

   task automatic launch(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel);
      cpu_ce_i   = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = wdata;
      cpu_sel_i  = sel;
   endtask

   task automatic drop_request;
      cpu_ce_i   = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_addr_i = '0;
      cpu_data_i = '0;
      cpu_sel_i  = '0;
   endtask

   // Slave script: per stb pulse, 'waits' idle cycles, then rty while n_rty remains,
   // then mode 0 = ack, 1 = err, 2 = silent. Called at cycle start in IDLE.
   task automatic access(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel, input int waits,
                         input int n_rty, input int mode, input logic [31:0] rdata,
                         output int pulses, output int stalls,
                         output logic [31:0] rdat, output logic rerr);
      int   wait_cnt;
      int   rty_left;
      int   gap;
      logic prev_stb;
      bit   done;
      pulses = 0; stalls = 0; rdat = '0; rerr = 1'b0;
      wait_cnt = 0; rty_left = n_rty; gap = 0; prev_stb = 1'b0; done = 1'b0;
      launch(we, addr, wdata, sel);
      settle;
      check({name, " launch stallreq"}, stallreq, 1);
      if (stallreq) stalls++;
      tick;
      drop_request;
      for (int c = 0; c < 60 && !done; c++) begin
         clear_bus_inputs;
         if (wb_stb_o) begin
            wb_dat_i = rdata;
            if (wait_cnt < waits) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               if (rty_left > 0) begin
                  wb_rty_i = 1'b1;
                  rty_left--;
               end else if (mode == 0) begin
                  wb_ack_i = 1'b1;
               end else if (mode == 1) begin
                  wb_err_i = 1'b1;
               end
            end
         end else begin
            wait_cnt = 0;
         end
         settle;
         if (wb_stb_o && !prev_stb) begin
            pulses++;
            if (pulses == 1) begin
               check({name, " adr"}, wb_adr_o, addr);
               check({name, " we"}, wb_we_o, we);
               check({name, " sel"}, wb_sel_o, sel);
               check({name, " dat_o"}, wb_dat_o, wdata);
            end else begin
               check({name, " stb gap"}, gap, 1);
            end
            gap = 0;
         end
         if (!wb_stb_o) gap++;
         prev_stb = wb_stb_o;
         if (!stallreq) begin
            done = 1'b1;
            rdat = cpu_data_o;
            rerr = cpu_err_o;
         end else begin
            stalls++;
            tick;
         end
      end
      if (!done) check({name, " terminated"}, 0, 1);
      tick;
      clear_bus_inputs;
      settle;
      check({name, " stb after"}, wb_stb_o, 0);
      check({name, " cyc after"}, wb_cyc_o, 0);
      $display("[TB] %s: pulses=%0d stalls=%0d data=%h err=%0b", name, pulses, stalls, rdat, rerr);
   endtask

   int          p;
   int          s;
   logic [31:0] d;
   logic        e;

   initial begin
      rst = 1'b1;
      stall_i = '0;
      flush_i = 1'b0;
      drop_request;
      clear_bus_inputs;
      cpu_ce_i = 1'b1;
      tick;
      tick;
      settle;
      check("reset stallreq", stallreq, 0);
      check("reset stb", wb_stb_o, 0);
      check("reset cyc", wb_cyc_o, 0);
      check("reset data", cpu_data_o, 0);
      check("reset err", cpu_err_o, 0);
      rst = 1'b0;
      cpu_ce_i = 1'b0;
      tick;

      access("rd0", 1'b0, 32'h100, 32'h0, 4'hF, 0, 0, 0, 32'hDEADBEEF, p, s, d, e);
      check("rd0 pulses", p, 1);
      check("rd0 stalls", s, 1);
      check("rd0 data", d, 32'hDEADBEEF);
      check("rd0 err", e, 0);
      tick;

      access("wr3", 1'b1, 32'h200, 32'h12345678, 4'b0011, 3, 0, 0, 32'hFFFFFFFF, p, s, d, e);
      check("wr3 stalls", s, 4);
      check("wr3 data", d, 0);
      check("wr3 err", e, 0);
      tick;

      stall_i = 6'b000011;
      access("hold", 1'b0, 32'h300, 32'h0, 4'hF, 0, 0, 0, 32'hCAFEF00D, p, s, d, e);
      check("hold ack data", d, 32'hCAFEF00D);
      check("hold1 data", cpu_data_o, 32'hCAFEF00D);
      check("hold1 stallreq", stallreq, 0);
      tick;
      flush_i = 1'b1;
      settle;
      check("hold2 data", cpu_data_o, 32'hCAFEF00D);
      check("hold2 stb", wb_stb_o, 0);
      tick;
      flush_i = 1'b0;
      stall_i = '0;
      settle;
      check("hold3 data", cpu_data_o, 32'hCAFEF00D);
      check("hold3 stallreq", stallreq, 0);
      tick;
      settle;
      check("hold idle data", cpu_data_o, 0);
      check("hold idle stb", wb_stb_o, 0);
      tick;

      access("rty2", 1'b0, 32'h400, 32'h0, 4'hF, 0, 2, 0, 32'h5A5A5A5A, p, s, d, e);
      check("rty2 pulses", p, 3);
      check("rty2 stalls", s, 5);
      check("rty2 data", d, 32'h5A5A5A5A);
      check("rty2 err", e, 0);
      tick;

      access("rty4", 1'b0, 32'h404, 32'h0, 4'hF, 0, 4, 0, 32'h11111111, p, s, d, e);
      check("rty4 pulses", p, 4);
      check("rty4 stalls", s, 7);
      check("rty4 data", d, 0);
      check("rty4 err", e, 1);
      tick;

      access("tmo", 1'b0, 32'h500, 32'h0, 4'hF, 0, 0, 2, 32'h22222222, p, s, d, e);
      check("tmo pulses", p, 1);
      check("tmo stalls", s, 8);
      check("tmo data", d, 0);
      check("tmo err", e, 1);
      tick;

      stall_i = 6'b000100;
      access("err2", 1'b0, 32'h600, 32'h0, 4'hF, 1, 0, 1, 32'h33333333, p, s, d, e);
      check("err2 stalls", s, 2);
      check("err2 data", d, 0);
      check("err2 err", e, 1);
      check("err2 hold err", cpu_err_o, 1);
      check("err2 hold data", cpu_data_o, 0);
      stall_i = '0;
      tick;
      settle;
      check("err2 idle err", cpu_err_o, 0);
      tick;

      access("rd_after", 1'b0, 32'h604, 32'h0, 4'h1, 0, 0, 0, 32'h44444444, p, s, d, e);
      check("rd_after data", d, 32'h44444444);
      check("rd_after err", e, 0);
      tick;

      launch(1'b0, 32'h700, 32'h0, 4'hF);
      tick;
      drop_request;
      flush_i = 1'b1;
      settle;
      check("flush_busy stallreq", stallreq, 0);
      tick;
      flush_i = 1'b0;
      settle;
      check("flush_busy stb", wb_stb_o, 0);
      check("flush_busy adr", wb_adr_o, 0);
      check("flush_busy idle stallreq", stallreq, 0);
      tick;

      launch(1'b0, 32'h800, 32'h0, 4'hF);
      tick;
      drop_request;
      wb_rty_i = 1'b1;
      settle;
      check("flush_bo busy stallreq", stallreq, 1);
      tick;
      wb_rty_i = 1'b0;
      flush_i = 1'b1;
      settle;
      check("flush_bo stallreq", stallreq, 0);
      check("flush_bo stb low", wb_stb_o, 0);
      check("flush_bo adr held", wb_adr_o, 32'h800);
      tick;
      flush_i = 1'b0;
      settle;
      check("flush_bo stb", wb_stb_o, 0);
      check("flush_bo cyc", wb_cyc_o, 0);
      check("flush_bo adr", wb_adr_o, 0);
      tick;

      launch(1'b1, 32'h900, 32'hAAAA5555, 4'hF);
      tick;
      drop_request;
      settle;
      check("rst_busy stb before", wb_stb_o, 1);
      rst = 1'b1;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'hBBBBBBBB;
      #1;
      check("rst_busy stallreq", stallreq, 0);
      check("rst_busy data", cpu_data_o, 0);
      check("rst_busy err", cpu_err_o, 0);
      tick;
      clear_bus_inputs;
      settle;
      check("rst_busy stb", wb_stb_o, 0);
      check("rst_busy cyc", wb_cyc_o, 0);
      check("rst_busy adr", wb_adr_o, 0);
      check("rst_busy dat_o", wb_dat_o, 0);
      check("rst_busy we", wb_we_o, 0);
      rst = 1'b0;
      tick;

      launch(1'b0, 32'hA00, 32'h0, 4'hF);
      flush_i = 1'b1;
      settle;
      check("ce_flush stallreq", stallreq, 0);
      tick;
      drop_request;
      flush_i = 1'b0;
      settle;
      check("ce_flush stb", wb_stb_o, 0);
      check("ce_flush cyc", wb_cyc_o, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
